alu_serial_addsub: RTL
======================

Name: alu_serial_addsub

Overview:
- Digit-serial WIDTH-bit add/subtract engine. It processes one 2-bit digit per clock, using the same arithmetic semantics as the team's 2-bit ALU slice.
- It owns the operand side (accept, shift, sequence) and the result side (collect, hold until consumed), with valid/ready handshakes on both.
- It sits between a command source and a result consumer. It extends the combinational 2-bit slice to wide words without a wide carry chain.

Parameters:
- WIDTH, 8, operand/result width in bits. Must be even and >= 2. DIGITS = WIDTH/2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start_valid  input  1  command valid
- start_ready  output  1  engine can accept a command
- op_a  input  WIDTH  first operand (in1)
- op_b  input  WIDTH  second operand (in2)
- sel  input  1  0 = add, 1 = subtract (magnitude)
- res_valid  output  1  result/carry valid
- res_ready  input  1  consumer accepts result
- result  output  WIDTH  sum, or |op_a - op_b|
- carry  output  1  add: carry-out; sub: 1 when op_a < op_b
- busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - start_ready=1 once released; res_valid=0, result=0, carry=0, busy=0.
  - Internal shift registers and carry are cleared.
  - Reset mid-operation aborts the command with no result.
- States: IDLE, RUN, NEG, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid&start_ready: capture op_a, op_b, sel into A/B shift registers.
  - Digit counter=0. c=sel (1 for sub, i.e. +1 of two's complement). Go to RUN.
- RUN, one digit per cycle, LSB first:
  - d = A[1:0] + (sel ? ~B[1:0] : B[1:0]) + c, which is 3 bits.
  - The result register shifts right by 2 with d[1:0] inserted at the top; c = d[2].
  - A and B shift right by 2.
  - After DIGITS cycles:
    - Add: carry=c, go to DONE.
    - Sub with c=1 (no borrow, op_a >= op_b): carry=0, go to DONE.
    - Sub with c=0: go to NEG with c=1, counter=0.
- NEG:
  - Digit-serial two's-complement negate of the result register: d = ~R[1:0] + c; R shifts right 2 with d[1:0] inserted; c = d[2].
  - After DIGITS cycles: carry=1, go to DONE.
- DONE:
  - res_valid=1. result and carry are held stable.
  - On res_ready: res_valid=0 next cycle, go to IDLE.
  - start_ready=0 in every state except IDLE. There is no overlap, giving a minimum 1-cycle gap between commands.
- Latency, counted in rising edges from the accept edge to the first cycle with res_valid=1:
  - Add: DIGITS.
  - Sub with op_a >= op_b: DIGITS.
  - Sub with op_a < op_b: 2*DIGITS.
- Width rules:
  - Add result wraps mod 2^WIDTH, with the overflow bit on carry.
  - Sub magnitude always fits in WIDTH bits.
  - op_a == op_b gives result=0, carry=0.
- start_valid asserted while busy is ignored and not queued. Operand inputs are sampled only at the accept edge.
- res_ready held high before DONE has no effect.

Optional Feature:
- Macro ALU_SERIAL_ZERO_EN.
- When defined:
  - Adds output port zero (1 bit), valid with res_valid.
  - zero=1 when the final result == 0.
  - zero is accumulated digit-serially: it is an OR of emitted digits, re-cleared at the start of NEG and recomputed during NEG. No wide comparator.
  - zero resets to 0.
- When undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

Test Plan (WIDTH=8):
- Add 0x5A + 0x3C:
  - res_valid 4 edges after accept.
  - result=0x96, carry=0 (zero=0).
- Add 0xFF + 0x01:
  - result=0x00, carry=1 (zero=1).
- Sub 0x3C − 0x1A:
  - Latency 4.
  - result=0x22, carry=0.
- Sub 0x1A − 0x3C:
  - Latency 8 (passes through NEG).
  - result=0x22, carry=1.
- Sub 0x00 − 0xFF:
  - result=0xFF, carry=1.
- Backpressure and reset:
  - Hold res_ready=0 for 5 cycles in DONE: result and carry stay stable, start_ready=0, and a start_valid pulse is ignored. Then res_ready=1: IDLE next cycle and a new command is accepted.
  - Assert rst_n=0 during RUN digit 2: all outputs are 0 immediately. After release, start_ready=1 and no stale res_valid appears.

Source files
------------

// File: rtl/alu_serial_addsub.sv
// alu_serial_addsub: digit-serial WIDTH-bit add / magnitude-subtract engine.
//
// One 2-bit digit is processed per clock, LSB first, so no wide carry chain is
// needed. A subtraction that borrows (op_a < op_b) takes a second pass that
// negates the collected result digit-serially, giving |op_a - op_b|.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start_valid  command valid
//   start_ready  engine idle and able to accept a command
//   op_a, op_b   operands, sampled only on the accept edge
//   sel          0 = add, 1 = subtract (magnitude)
//   res_valid    result/carry valid, held until res_ready
//   res_ready    consumer accepts the result
//   result       sum mod 2^WIDTH, or |op_a - op_b|
//   carry        add: carry-out; sub: 1 when op_a < op_b
//   busy         engine is not idle
//   zero         (ALU_SERIAL_ZERO_EN only) final result == 0, valid with res_valid
//
// Configuration macro: ALU_SERIAL_ZERO_EN adds the zero flag output.
//
// WIDTH must be even and >= 2.

module alu_serial_addsub #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             sel,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             busy
`ifdef ALU_SERIAL_ZERO_EN
   ,
   output logic             zero
`endif
);

   localparam int unsigned DIGITS = WIDTH / 2;
   localparam int unsigned CntW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StNeg  = 2'd2;
   localparam logic [1:0] StDone = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             sel_q, sel_d;
   logic             c_q, c_d;
   logic             carry_q, carry_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
`ifdef ALU_SERIAL_ZERO_EN
   // Sticky "some emitted digit was non-zero" flag.
   logic             nz_q, nz_d;
`endif

   logic [1:0]       b_dig;
   logic [2:0]       run_sum;
   logic [2:0]       neg_sum;
   logic [WIDTH-1:0] run_ins;
   logic [WIDTH-1:0] neg_ins;
   logic             last_dig;

   // Subtraction adds ~B with an initial carry of 1 (two's complement).
   assign b_dig    = sel_q ? ~b_q[1:0] : b_q[1:0];
   assign run_sum  = {1'b0, a_q[1:0]} + {1'b0, b_dig} + {2'b00, c_q};
   assign neg_sum  = {1'b0, ~r_q[1:0]} + {2'b00, c_q};
   // New digits enter at the top so after DIGITS shifts they sit in place.
   assign run_ins  = WIDTH'(run_sum[1:0]) << (WIDTH - 2);
   assign neg_ins  = WIDTH'(neg_sum[1:0]) << (WIDTH - 2);
   assign last_dig = (cnt_q == CntW'(DIGITS - 1));

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      sel_d   = sel_q;
      c_d     = c_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
`ifdef ALU_SERIAL_ZERO_EN
      nz_d    = nz_q;
`endif

      case (state_q)
         StIdle: begin
            if (start_valid) begin
               a_d     = op_a;
               b_d     = op_b;
               sel_d   = sel;
               c_d     = sel;
               cnt_d   = '0;
               state_d = StRun;
`ifdef ALU_SERIAL_ZERO_EN
               nz_d    = 1'b0;
`endif
            end
         end

         StRun: begin
            r_d   = (r_q >> 2) | run_ins;
            a_d   = a_q >> 2;
            b_d   = b_q >> 2;
            c_d   = run_sum[2];
            cnt_d = cnt_q + CntW'(1);
`ifdef ALU_SERIAL_ZERO_EN
            nz_d  = nz_q | (|run_sum[1:0]);
`endif
            if (last_dig) begin
               cnt_d = '0;
               if (!sel_q) begin
                  carry_d = run_sum[2];
                  state_d = StDone;
               end else if (run_sum[2]) begin
                  // No borrow: op_a >= op_b, result already the magnitude.
                  carry_d = 1'b0;
                  state_d = StDone;
               end else begin
                  // Borrow: result holds op_a - op_b mod 2^WIDTH; negate it.
                  c_d     = 1'b1;
                  state_d = StNeg;
`ifdef ALU_SERIAL_ZERO_EN
                  nz_d    = 1'b0;
`endif
               end
            end
         end

         StNeg: begin
            r_d   = (r_q >> 2) | neg_ins;
            c_d   = neg_sum[2];
            cnt_d = cnt_q + CntW'(1);
`ifdef ALU_SERIAL_ZERO_EN
            nz_d  = nz_q | (|neg_sum[1:0]);
`endif
            if (last_dig) begin
               cnt_d   = '0;
               carry_d = 1'b1;
               state_d = StDone;
            end
         end

         StDone: begin
            if (res_ready) begin
               state_d = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         sel_q   <= 1'b0;
         c_q     <= 1'b0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
`ifdef ALU_SERIAL_ZERO_EN
         nz_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         sel_q   <= sel_d;
         c_q     <= c_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
`ifdef ALU_SERIAL_ZERO_EN
         nz_q    <= nz_d;
`endif
      end
   end

   // Gated with rst_n so start_ready reads 0 while reset is held.
   assign start_ready = (state_q == StIdle) && rst_n;
   assign res_valid   = (state_q == StDone);
   assign busy        = (state_q != StIdle);
   assign result      = r_q;
   assign carry       = carry_q;
`ifdef ALU_SERIAL_ZERO_EN
   assign zero        = (state_q == StDone) && !nz_q;
`endif

endmodule
